fetch_queue: RTL

Parametrised instruction-fetch front end with a decoupling buffer, the successor to the single-register fetch stage. It generates the PC with priority trap > branch > sequential, issues requests over a valid/ready instruction-memory port with arbitrary in-order latency, and buffers up to DEPTH returned instructions and their PCs. Decode drains the buffer through a valid/ready port. Redirects flush the buffer and discard stale in-flight responses.

---
 rtl/fetch_queue.sv | 127 ++++++++++++
 1 files changed

// File: rtl/fetch_queue.sv
// Instruction-fetch front end: PC generation (trap > branch > sequential), credit-limited
// imem requests with in-order tag tracking, and a DEPTH-entry {pc, instr} decode buffer.
module fetch_queue #(
    parameter int          N        = 64,
    parameter int          ILEN     = 32,
    parameter int          DEPTH    = 4,
    parameter logic [N-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [N-1:0]    PC_Trap,
    input  logic            interruptSignal,
    input  logic [N-1:0]    PCBranch_F,
    input  logic            PCSrc_F,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [N-1:0]    imem_addr_F,
    input  logic            imem_resp_valid,
    input  logic [ILEN-1:0] imem_resp_data,
    output logic            inst_valid_D,
    input  logic            inst_ready_D,
    output logic [ILEN-1:0] inst_D,
    output logic [N-1:0]    pc_D
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int SW = CW + 2;

    logic [N-1:0]    pc;
    logic [N-1:0]    buf_pc    [DEPTH];
    logic [ILEN-1:0] buf_instr [DEPTH];
    logic [N-1:0]    tag_pc    [DEPTH];
    logic [PW-1:0]   head;
    logic [PW-1:0]   tail;
    logic [PW-1:0]   tag_head;
    logic [PW-1:0]   tag_tail;
    logic [CW-1:0]   count;
    logic [CW-1:0]   outstanding;
    logic [CW-1:0]   drop;

    logic            redirect;
    logic [N-1:0]    target;
    logic [SW-1:0]   credit_used;
    logic            req_fire;
    logic            resp_stale;
    logic            resp_live;
    logic            enq;
    logic            deq;

    // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
    // valid never depends on ready, and responses are accepted unconditionally.
    assign redirect    = interruptSignal | PCSrc_F;
    assign target      = interruptSignal ? PC_Trap : PCBranch_F;
    assign credit_used = SW'(count) + SW'(outstanding) + SW'(drop);

    assign imem_req_valid = reset & ~redirect & (credit_used < SW'(DEPTH));
    assign imem_addr_F    = pc;
    assign req_fire       = imem_req_valid & imem_req_ready;

    // Stale responses (issued before a redirect) are consumed first, in order.
    assign resp_stale = imem_resp_valid & (drop != '0);
    assign resp_live  = imem_resp_valid & (drop == '0);
    assign enq        = resp_live & ~redirect;

    assign inst_valid_D = (count != '0) & ~redirect;
    assign deq          = inst_valid_D & inst_ready_D;
    assign inst_D       = buf_instr[head];
    assign pc_D         = buf_pc[head];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc          <= RESET_PC;
            head        <= '0;
            tail        <= '0;
            tag_head    <= '0;
            tag_tail    <= '0;
            count       <= '0;
            outstanding <= '0;
            drop        <= '0;
        end else if (redirect) begin
            // Every in-flight request, minus one answered this cycle, becomes stale.
            pc          <= target;
            head        <= '0;
            tail        <= '0;
            tag_head    <= '0;
            tag_tail    <= '0;
            count       <= '0;
            outstanding <= '0;
            drop        <= drop + outstanding - CW'(imem_resp_valid);
        end else begin
            if (req_fire) begin
                pc       <= pc + N'(4);
                tag_tail <= tag_tail + PW'(1);
            end
            if (enq) begin
                tail     <= tail + PW'(1);
                tag_head <= tag_head + PW'(1);
            end
            if (deq) begin
                head <= head + PW'(1);
            end
            if (resp_stale) begin
                drop <= drop - CW'(1);
            end
            count       <= count + CW'(enq) - CW'(deq);
            outstanding <= outstanding + CW'(req_fire) - CW'(enq);
        end
    end

    always_ff @(posedge clk) begin
        if (req_fire) begin
            tag_pc[tag_tail] <= pc;
        end
        if (enq) begin
            buf_pc[tail]    <= tag_pc[tag_head];
            buf_instr[tail] <= imem_resp_data;
        end
    end

`ifndef SYNTHESIS
    // The credit rule makes a live response into a full buffer impossible.
    assert property (@(posedge clk) disable iff (!reset)
        !(resp_live && (count == CW'(DEPTH))))
        else $error("fetch_queue: live response arrived with buffer full");
`endif

endmodule
